energy_detect_ctrl: RTL and testbench
=====================================

# energy_detect_ctrl

Parametrised windowed energy detector for the spectrum-sensing receive path. It sits after the DDC strobe in the E1x0 FPGA. For each window of 2^L strobed I/Q samples it accumulates instantaneous power (I²+Q²) and divides by a right-shift to get the average. The average is compared with a programmable threshold, and `detect` asserts only after a programmable number of consecutive windows exceed it. The block integrates the FIFO-write/store/detect sequencing with an on-chip accumulator, a runtime window length, a consecutive-hit qualifier, overrun reporting and run/abort control.

## Interface
- `IW`, 16: signed I and Q sample width.
- `MAX_LOG2_N`, 10: largest supported log2 window length.
- `CW`, 4: width of the consecutive-hit count.
- Derived: PW = 2·IW (unsigned power width); AW = PW + MAX_LOG2_N (accumulator width).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `run` in 1: level; 1 = detector enabled.
- `strobe` in 1: sample valid, one cycle per sample.
- `i_in` in IW: signed I sample, sampled when `strobe`=1.
- `q_in` in IW: signed Q sample, sampled when `strobe`=1.
- `log2_len` in 4: window length exponent L, latched at window start.
- `threshold` in PW: unsigned power threshold.
- `consec` in CW: consecutive hits required; 0 is treated as 1.
- `avg_power` out PW: last window average.
- `avg_valid` out 1: one-cycle pulse when `avg_power` updates.
- `detect` out 1: qualified detection flag (level).
- `overrun` out 1: one-cycle pulse when a strobe is dropped.
- `state` out 3: current FSM state, for debug.

## Operation
- States: IDLE=0, ACCUM=1, AVERAGE=2, COMPARE=3.
- Reset values: state=IDLE; acc, sample count, hit count, `avg_power`=0; `avg_valid`, `detect`, `overrun`=0.
- IDLE:
  - `run`=1 → ACCUM. On entry, acc and sample count clear.
  - L latches as min(`log2_len`, MAX_LOG2_N).
  - Strobes in IDLE are ignored; no overrun is reported.
- ACCUM: on each `strobe`, acc += i_in² + q_in² (full-precision unsigned; max 2^(2IW−1) fits PW), and the count increments.
  - Strobe with count = 2^L−1 → AVERAGE.
  - L=0 is a 1-sample window.
- AVERAGE:
  - `avg_power` ← acc >> L (low PW bits, truncating).
  - `avg_valid` pulses.
  - Next state: COMPARE.
- COMPARE:
  - hit = `avg_power` > `threshold` (strict).
  - On a hit, the hit count increments, saturating at 2^CW−1. On a miss it clears to 0.
  - `detect` ← hit AND (new count ≥ max(`consec`,1)).
  - acc and sample count clear, and L re-latches.
  - Next state: ACCUM.
- A strobe in AVERAGE or COMPARE is dropped and pulses `overrun` the next cycle.
- `run`=0 in any non-IDLE state → IDLE at the next edge. This clears acc, sample count, hit count and `detect`. An in-flight window is discarded and no `avg_valid` is produced.
- Asynchronous `rst` mid-window returns every output to its reset value immediately.

## Timing
- Edge E0 is the final strobe of a window: acc updates, and state goes to AVERAGE.
- E1: `avg_power` and `avg_valid` are registered, so they are visible in the cycle after E1.
- E2: `detect` updates. The first sample of the next window is accepted from E3 onward.
- Average latency is 2 edges after the last sample; detect latency is 3.
- The minimum inter-window gap is 2 cycles. Strobe duty must leave these 2 cycles free, or `overrun` is reported.
- `threshold` and `consec` are sampled at the COMPARE edge. `log2_len` is sampled only at window start.

## Structure
- `energy_det_pkg` holds:
  - state encoding localparams;
  - PW/AW derivation;
  - the saturating-increment function.
- Sub-module `power_accum`: signed squarer, adder and AW-bit accumulator, with `clr` and `en` inputs and the right-shift output.
- The top level holds the FSM, sample count, hit count and output registers.
- Target size is 150–250 lines total.

## Test plan
- **Basic window:**
  - Stimulus: L=2; 4 strobes with i=q=100; threshold=19999; consec=1.
  - Response: `avg_power`=20000, `avg_valid` pulses 2 edges after the 4th strobe, and `detect`=1 one edge later.
- **Negative full-scale and truncation:**
  - Stimulus: L=1; samples (−32768,−32768) then (0,1).
  - Response: acc = 2^31+1 and `avg_power` = 2^30 (truncated).
- **Consecutive qualification:**
  - Stimulus: consec=3; window averages 500, 500, 10, 500, 500, 500 against threshold 100.
  - Response: `detect` stays 0 until the COMPARE of the 6th window, then goes 1. A following window of 10 returns it to 0.
- **Overrun:**
  - Stimulus: continuous strobe every cycle with L=0.
  - Response: every 2nd and 3rd strobe after each accepted one pulses `overrun`. `avg_valid` occurs every 3 cycles.
- **Abort:**
  - Stimulus: deassert `run` after 5 of 8 samples (L=3), then reassert.
  - Response: no `avg_valid`, and `detect`=0. The next window needs 8 fresh samples.
- **Reset mid-COMPARE and clamps:**
  - Stimulus: assert `rst` during COMPARE; separately run with `log2_len`=15 and `consec`=0.
  - Response: reset drives all outputs to 0 with no clock edge. The clamped run uses L=MAX_LOG2_N and consec behaves as 1.

Source files
------------

// File: rtl/energy_det_pkg.sv
// Shared types and helpers for the windowed energy detector.
package energy_det_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCUM   = 3'd1,
    AVERAGE = 3'd2,
    COMPARE = 3'd3
  } state_e;

  localparam int DEF_IW         = 16;
  localparam int DEF_MAX_LOG2_N = 10;
  localparam int DEF_CW         = 4;

  // Unsigned instantaneous power width for IW-bit signed I/Q.
  function automatic int pw_width(input int iw);
    return 2 * iw;
  endfunction

  // Accumulator width: power width plus headroom for 2^MAX_LOG2_N samples.
  function automatic int aw_width(input int iw, input int maxLog2N);
    return 2 * iw + maxLog2N;
  endfunction

  // Increment that sticks at the all-ones value of a counter of the given width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] maxVal;
    maxVal = (32'd1 << width) - 32'd1;
    return (value >= maxVal) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/energy_detect_ctrl_accum.sv
// Squares each I/Q sample, sums the power and accumulates it over a window.
module power_accum
  import energy_det_pkg::*;
#(
  parameter int IW         = DEF_IW,
  parameter int MAX_LOG2_N = DEF_MAX_LOG2_N,
  localparam int PW        = pw_width(IW),
  localparam int AW        = aw_width(IW, MAX_LOG2_N)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic signed [IW-1:0] i_i,
  input  logic signed [IW-1:0] q_i,
  input  logic [3:0]           shift_i,
  output logic [AW-1:0]        acc_o,
  output logic [PW-1:0]        avg_o
);

  logic signed [PW-1:0] iSq;
  logic signed [PW-1:0] qSq;
  logic [PW-1:0]        power;
  logic [AW-1:0]        acc_q;
  logic [AW-1:0]        acc_d;

  // Squares are non-negative and each is at most 2^(2IW-2), so the sum fits PW unsigned bits.
  always_comb begin
    iSq   = PW'(i_i) * PW'(i_i);
    qSq   = PW'(q_i) * PW'(q_i);
    power = $unsigned(iSq) + $unsigned(qSq);
  end

  // Clear has priority so a new window never inherits a stale sum.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + AW'(power);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;
  assign avg_o = PW'(acc_q >> shift_i);

endmodule

// File: rtl/energy_detect_ctrl.sv
// Windowed energy detector: accumulate, average, compare, qualify consecutive hits.
module energy_detect_ctrl
  import energy_det_pkg::*;
#(
  parameter int IW         = DEF_IW,
  parameter int MAX_LOG2_N = DEF_MAX_LOG2_N,
  parameter int CW         = DEF_CW,
  localparam int PW        = pw_width(IW),
  localparam int AW        = aw_width(IW, MAX_LOG2_N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 strobe,
  input  logic signed [IW-1:0] i_in,
  input  logic signed [IW-1:0] q_in,
  input  logic [3:0]           log2_len,
  input  logic [PW-1:0]        threshold,
  input  logic [CW-1:0]        consec,
  output logic [PW-1:0]        avg_power,
  output logic                 avg_valid,
  output logic                 detect,
  output logic                 overrun,
  output logic [2:0]           state
);

  state_e                state_q, state_d;
  logic [MAX_LOG2_N-1:0] count_q, count_d;
  logic [CW-1:0]         hit_q, hit_d;
  logic [3:0]            l_q, l_d;
  logic [PW-1:0]         avg_q, avg_d;
  logic                  avgValid_q, avgValid_d;
  logic                  detect_q, detect_d;
  logic                  overrun_q, overrun_d;

  logic                  accClr;
  logic                  accEn;
  logic                  hit;
  logic [AW-1:0]         accSum;
  logic [PW-1:0]         accAvg;
  logic [3:0]            lClamp;
  logic [CW-1:0]         consecEff;
  logic [MAX_LOG2_N-1:0] lastIdx;

  assign lClamp    = (log2_len > 4'(MAX_LOG2_N)) ? 4'(MAX_LOG2_N) : log2_len;
  assign consecEff = (consec == '0) ? CW'(1) : consec;
  assign lastIdx   = (MAX_LOG2_N'(1) << l_q) - MAX_LOG2_N'(1);

  power_accum #(
    .IW         (IW),
    .MAX_LOG2_N (MAX_LOG2_N)
  ) u_accum (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (accClr),
    .en_i    (accEn),
    .i_i     (i_in),
    .q_i     (q_in),
    .shift_i (l_q),
    .acc_o   (accSum),
    .avg_o   (accAvg)
  );

  // Next-state and output logic; a dropped run aborts the window from any active state.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    hit_d      = hit_q;
    l_d        = l_q;
    avg_d      = avg_q;
    avgValid_d = 1'b0;
    detect_d   = detect_q;
    overrun_d  = strobe && ((state_q == AVERAGE) || (state_q == COMPARE));
    accClr     = 1'b0;
    accEn      = 1'b0;
    hit        = 1'b0;

    case (state_q)
      IDLE: begin
        accClr  = 1'b1;
        count_d = '0;
        l_d     = lClamp;
        if (run) state_d = ACCUM;
      end
      ACCUM: begin
        if (strobe) begin
          accEn   = 1'b1;
          count_d = count_q + MAX_LOG2_N'(1);
          if (count_q == lastIdx) state_d = AVERAGE;
        end
      end
      AVERAGE: begin
        avg_d      = accAvg;
        avgValid_d = 1'b1;
        state_d    = COMPARE;
      end
      COMPARE: begin
        hit      = (avg_q > threshold);
        hit_d    = hit ? CW'(sat_inc(32'(hit_q), CW)) : '0;
        detect_d = hit && (hit_d >= consecEff);
        accClr   = 1'b1;
        count_d  = '0;
        l_d      = lClamp;
        state_d  = ACCUM;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (!run && (state_q != IDLE)) begin
      state_d    = IDLE;
      accClr     = 1'b1;
      accEn      = 1'b0;
      count_d    = '0;
      hit_d      = '0;
      detect_d   = 1'b0;
      avg_d      = avg_q;
      avgValid_d = 1'b0;
      l_d        = l_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      hit_q      <= '0;
      l_q        <= '0;
      avg_q      <= '0;
      avgValid_q <= 1'b0;
      detect_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      hit_q      <= hit_d;
      l_q        <= l_d;
      avg_q      <= avg_d;
      avgValid_q <= avgValid_d;
      detect_q   <= detect_d;
      overrun_q  <= overrun_d;
    end
  end

  assign avg_power = avg_q;
  assign avg_valid = avgValid_q;
  assign detect    = detect_q;
  assign overrun   = overrun_q;
  assign state     = state_q;

endmodule

// File: tb/tb_energy_detect_ctrl.sv
// Directed self-checking bench for energy_detect_ctrl.
module tb_energy_detect_ctrl;

  logic               clk;
  logic               rst;
  logic               run;
  logic               strobe;
  logic signed [15:0] iIn;
  logic signed [15:0] qIn;
  logic [3:0]         log2Len;
  logic [31:0]        threshold;
  logic [3:0]         consec;
  logic [31:0]        avgPower;
  logic               avgValid;
  logic               detect;
  logic               overrun;
  logic [2:0]         state;

  int testCount = 0;
  int failCount = 0;

  energy_detect_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .strobe    (strobe),
    .i_in      (iIn),
    .q_in      (qIn),
    .log2_len  (log2Len),
    .threshold (threshold),
    .consec    (consec),
    .avg_power (avgPower),
    .avg_valid (avgValid),
    .detect    (detect),
    .overrun   (overrun),
    .state     (state)
  );

  // 10 ns free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic signed [15:0] i, input logic signed [15:0] q);
    strobe = 1'b1;
    iIn    = i;
    qIn    = q;
    tick();
    strobe = 1'b0;
  endtask

  // Checks the post-window sequence: AVERAGE, then avg_valid, then detect.
  task automatic finishWindow(input logic [31:0] expAvg, input logic expDet, input string tag);
    checkOutput({tag, "_stAvg"}, 64'(state), 64'd2);
    checkOutput({tag, "_noValidYet"}, 64'(avgValid), 64'd0);
    tick();
    checkOutput({tag, "_valid"}, 64'(avgValid), 64'd1);
    checkOutput({tag, "_avg"}, 64'(avgPower), 64'(expAvg));
    tick();
    checkOutput({tag, "_validDone"}, 64'(avgValid), 64'd0);
    checkOutput({tag, "_detect"}, 64'(detect), 64'(expDet));
    checkOutput({tag, "_stAccum"}, 64'(state), 64'd1);
  endtask

  task automatic runWindow(input int n, input logic signed [15:0] i, input logic signed [15:0] q,
                           input logic [31:0] expAvg, input logic expDet, input string tag);
    for (int k = 0; k < n; k++) applyStimulus(i, q);
    finishWindow(expAvg, expDet, tag);
  endtask

  // Drops run for one edge, loads a new window length, and restarts.
  task automatic restart(input logic [3:0] newLen);
    run = 1'b0;
    tick();
    checkOutput("abort_idle", 64'(state), 64'd0);
    checkOutput("abort_detect", 64'(detect), 64'd0);
    log2Len = newLen;
    run     = 1'b1;
    tick();
    checkOutput("restart_accum", 64'(state), 64'd1);
  endtask

  initial begin
    rst       = 1'b1;
    run       = 1'b0;
    strobe    = 1'b0;
    iIn       = '0;
    qIn       = '0;
    log2Len   = 4'd2;
    threshold = 32'd19999;
    consec    = 4'd1;
    #2;
    checkOutput("rst_state", 64'(state), 64'd0);
    checkOutput("rst_avg", 64'(avgPower), 64'd0);
    checkOutput("rst_flags", 64'({avgValid, detect, overrun}), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("idle_hold", 64'(state), 64'd0);

    // Basic window: L=2, four samples of power 20000.
    run = 1'b1;
    tick();
    checkOutput("start_accum", 64'(state), 64'd1);
    runWindow(4, 16'sd100, 16'sd100, 32'd20000, 1'b1, "basic");

    // Negative full scale and truncation, L=1.
    restart(4'd1);
    threshold = 32'hFFFF_FFFF;
    applyStimulus(16'sh8000, 16'sh8000);
    applyStimulus(16'sd0, 16'sd1);
    checkOutput("fs_acc", 64'(dut.u_accum.acc_q), 64'h8000_0001);
    finishWindow(32'h4000_0000, 1'b0, "fullscale");

    // Consecutive qualification with consec=3, L=1.
    threshold = 32'd100;
    consec    = 4'd3;
    runWindow(2, 16'sd10, 16'sd20, 32'd500, 1'b0, "c1");
    runWindow(2, 16'sd10, 16'sd20, 32'd500, 1'b0, "c2");
    runWindow(2, 16'sd1,  16'sd3,  32'd10,  1'b0, "c3");
    runWindow(2, 16'sd10, 16'sd20, 32'd500, 1'b0, "c4");
    runWindow(2, 16'sd10, 16'sd20, 32'd500, 1'b0, "c5");
    runWindow(2, 16'sd10, 16'sd20, 32'd500, 1'b1, "c6");
    runWindow(2, 16'sd1,  16'sd3,  32'd10,  1'b0, "c7");

    // Overrun: continuous strobe with L=0, power 50 per sample.
    restart(4'd0);
    strobe = 1'b1;
    iIn    = 16'sd5;
    qIn    = 16'sd5;
    for (int w = 0; w < 3; w++) begin
      tick();
      checkOutput("ov_accepted", 64'({overrun, avgValid}), 64'd0);
      checkOutput("ov_stAvg", 64'(state), 64'd2);
      tick();
      checkOutput("ov_drop1", 64'(overrun), 64'd1);
      checkOutput("ov_valid", 64'(avgValid), 64'd1);
      checkOutput("ov_avg", 64'(avgPower), 64'd50);
      tick();
      checkOutput("ov_drop2", 64'(overrun), 64'd1);
      checkOutput("ov_validDone", 64'(avgValid), 64'd0);
    end
    strobe = 1'b0;
    tick();
    checkOutput("ov_quiet", 64'(overrun), 64'd0);

    // Abort after 5 of 8 samples, then a fresh 8-sample window.
    restart(4'd3);
    threshold = 32'd0;
    consec    = 4'd1;
    for (int k = 0; k < 5; k++) applyStimulus(16'sd1, 16'sd1);
    run = 1'b0;
    tick();
    checkOutput("ab_idle", 64'(state), 64'd0);
    checkOutput("ab_noValid", 64'({avgValid, detect}), 64'd0);
    tick();
    checkOutput("ab_noValid2", 64'(avgValid), 64'd0);
    run = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) applyStimulus(16'sd2, 16'sd0);
    checkOutput("ab_stillAccum", 64'(state), 64'd1);
    runWindow(1, 16'sd2, 16'sd0, 32'd4, 1'b1, "abfresh");

    // Asynchronous reset while in COMPARE.
    for (int k = 0; k < 8; k++) applyStimulus(16'sd2, 16'sd0);
    tick();
    checkOutput("pre_rst_compare", 64'(state), 64'd3);
    checkOutput("pre_rst_valid", 64'(avgValid), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_state", 64'(state), 64'd0);
    checkOutput("mid_rst_avg", 64'(avgPower), 64'd0);
    checkOutput("mid_rst_flags", 64'({avgValid, detect, overrun}), 64'd0);

    // Clamped run: log2_len=15 acts as 10, consec=0 acts as 1.
    rst       = 1'b0;
    log2Len   = 4'd15;
    consec    = 4'd0;
    threshold = 32'd0;
    tick();
    checkOutput("clamp_accum", 64'(state), 64'd1);
    for (int k = 0; k < 1023; k++) applyStimulus(16'sd3, 16'sd4);
    checkOutput("clamp_notDone", 64'(state), 64'd1);
    runWindow(1, 16'sd3, 16'sd4, 32'd25, 1'b1, "clamp");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
